// File: rtl/video_text_gen_if.sv
// Host write port of the video text generator's character RAM.
//   wr_en   : write strobe, sampled on every clk edge
//   wr_addr : cell index = row*COLS + col (out-of-range indices are dropped)
//   wr_data : {attr[3:0] = IRGB foreground, code[7:0]}
// master : driven by the host/CPU side
// slave  : consumed by video_text_gen
interface video_text_gen_if;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/video_text_gen.sv
// VGA timing generator with an 80x60 (default) character-cell text layer.
// Stage 0 holds the raw h/v counters; three pix_en-gated stages fetch the
// cell word, address the external font ROM, and pick the glyph bit, so rgb,
// hsync, vsync and blank leave three pixel ticks after x/y.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   pix_en             : pixel tick, every counter and stage advances on it
//   wr                 : host write port into the character RAM (slave)
//   font_addr/font_data: {code, glyph_row} out, glyph row back one tick later
//   cursor_addr        : blinking inverted cell (only with CURSOR_EN)
//   x, y               : stage-0 counters
//   hsync, vsync       : active-low syncs, aligned with rgb
//   blank              : high outside the active area, aligned with rgb
//   frame_start        : one-clock pulse when (0,0) enters stage 0
//   r, g, b            : pixel colour
// Build option: define CURSOR_EN to add the cursor input and the 6-bit frame
// counter that blinks it with a 64-frame period.
module video_text_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CHAR_WIDTH  = 8,
  parameter int CHAR_HEIGHT = 8,
  parameter int COLOR_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pix_en,
  video_text_gen_if.slave                 wr,
  output logic [7+$clog2(CHAR_HEIGHT):0]  font_addr,
  input  logic [CHAR_WIDTH-1:0]           font_data,
`ifdef CURSOR_EN
  input  logic [12:0]                     cursor_addr,
`endif
  output logic [9:0]                      x,
  output logic [9:0]                      y,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            blank,
  output logic                            frame_start,
  output logic [COLOR_W-1:0]              r,
  output logic [COLOR_W-1:0]              g,
  output logic [COLOR_W-1:0]              b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE / CHAR_WIDTH;
  localparam int ROWS    = V_ACTIVE / CHAR_HEIGHT;
  localparam int CELLS   = COLS * ROWS;
  localparam int AW      = $clog2(CELLS);
  localparam int XOFF_W  = $clog2(CHAR_WIDTH);
  localparam int YOFF_W  = $clog2(CHAR_HEIGHT);

  // Intensity scaling of one channel: full scale with I, MSB-only without.
  function automatic logic [COLOR_W-1:0] chan_level(input logic on, input logic inten);
    logic [COLOR_W-1:0] half;
    half = {1'b1, {(COLOR_W-1){1'b0}}};
    if (!on) return '0;
    return inten ? '1 : half;
  endfunction

  logic [11:0]        mem [CELLS];

  logic [9:0]         x_p0, y_p0;
  logic               x_last_p0, y_last_p0;
  logic               hsync_p0, vsync_p0, vld_p0, cur_p0;
  logic [AW-1:0]      rd_idx_p0;
  logic [XOFF_W-1:0]  xoff_p0;
  logic [YOFF_W-1:0]  yoff_p0;

  logic [11:0]        word_p1;
  logic [XOFF_W-1:0]  xoff_p1;
  logic [YOFF_W-1:0]  yoff_p1;
  logic               vld_p1, hsync_p1, vsync_p1, cur_p1;

  logic [3:0]         attr_p2;
  logic [XOFF_W-1:0]  xoff_p2, bit_sel_p2;
  logic               vld_p2, hsync_p2, vsync_p2, cur_p2, pix_p2;

  logic [COLOR_W-1:0] r_p3, g_p3, b_p3;
  logic               vld_p3, hsync_p3, vsync_p3;

  logic               blink;

  // Stage 0: counters, sync windows, cell lookup address
  always_comb begin
    x_last_p0 = (x_p0 == 10'(H_TOTAL - 1));
    y_last_p0 = (y_p0 == 10'(V_TOTAL - 1));
    hsync_p0  = !((x_p0 >= 10'(H_ACTIVE + H_FP)) && (x_p0 <= 10'(H_ACTIVE + H_FP + H_SYNC - 1)));
    vsync_p0  = !((y_p0 >= 10'(V_ACTIVE + V_FP)) && (y_p0 <= 10'(V_ACTIVE + V_FP + V_SYNC - 1)));
    vld_p0    = (x_p0 < 10'(H_ACTIVE)) && (y_p0 < 10'(V_ACTIVE));
    // Porch positions map past the RAM, so park the read on cell 0 there.
    rd_idx_p0 = vld_p0 ? AW'((y_p0 >> YOFF_W) * COLS + (x_p0 >> XOFF_W)) : '0;
    xoff_p0   = x_p0[XOFF_W-1:0];
    yoff_p0   = y_p0[YOFF_W-1:0];
  end

`ifdef CURSOR_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blink  = frame_cnt[5];
  assign cur_p0 = vld_p0 && (cursor_addr < 13'(CELLS)) && (cursor_addr == 13'(rd_idx_p0));
`else
  assign blink  = 1'b0;
  assign cur_p0 = 1'b0;
`endif

  // Writes are read-first against the pixel fetch and ignore pix_en.
  always_ff @(posedge clk) begin
    if (wr.wr_en && (wr.wr_addr < 13'(CELLS)))
      mem[wr.wr_addr[AW-1:0]] <= wr.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0        <= '0;
      y_p0        <= '0;
      frame_start <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
      hsync_p1    <= 1'b1;
      hsync_p2    <= 1'b1;
      hsync_p3    <= 1'b1;
      vsync_p1    <= 1'b1;
      vsync_p2    <= 1'b1;
      vsync_p3    <= 1'b1;
    end else begin
      frame_start <= pix_en && x_last_p0 && y_last_p0;
      if (pix_en) begin
        x_p0 <= x_last_p0 ? 10'd0 : x_p0 + 10'd1;
        if (x_last_p0)
          y_p0 <= y_last_p0 ? 10'd0 : y_p0 + 10'd1;
        vld_p1   <= vld_p0;
        hsync_p1 <= hsync_p0;
        vsync_p1 <= vsync_p0;
        vld_p2   <= vld_p1;
        hsync_p2 <= hsync_p1;
        vsync_p2 <= vsync_p1;
        vld_p3   <= vld_p2;
        hsync_p3 <= hsync_p2;
        vsync_p3 <= vsync_p2;
      end
    end
  end

  // Stage 1 -> 2: cell word drives the font ROM address
  assign font_addr = {word_p1[7:0], yoff_p1};

  // Stage 2 -> 3: glyph row is back from the ROM; MSB is the leftmost pixel
  always_comb begin
    bit_sel_p2 = ~xoff_p2;
    pix_p2     = font_data[bit_sel_p2] ^ (cur_p2 & blink);
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      word_p1 <= mem[rd_idx_p0];
      xoff_p1 <= xoff_p0;
      yoff_p1 <= yoff_p0;
      cur_p1  <= cur_p0;
      attr_p2 <= word_p1[11:8];
      xoff_p2 <= xoff_p1;
      cur_p2  <= cur_p1;
      r_p3    <= chan_level(pix_p2 & attr_p2[2], attr_p2[3]);
      g_p3    <= chan_level(pix_p2 & attr_p2[1], attr_p2[3]);
      b_p3    <= chan_level(pix_p2 & attr_p2[0], attr_p2[3]);
    end
  end

  // Stage 3: outputs; blanking forces black
  assign x     = x_p0;
  assign y     = y_p0;
  assign hsync = hsync_p3;
  assign vsync = vsync_p3;
  assign blank = ~vld_p3;
  assign r     = vld_p3 ? r_p3 : '0;
  assign g     = vld_p3 ? g_p3 : '0;
  assign b     = vld_p3 ? b_p3 : '0;
endmodule
